// File: rtl/store_buffer_if.sv
// Pipeline-side bundle for the MEM-stage store buffer: store/load requests in,
// stall and data-memory port controls out.
interface store_buffer_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Handshake: a store with st_valid=1 is taken at the rising edge unless
    // stall=1 in that cycle, in which case the pipeline holds and re-presents it.
    // A load with ld_valid=1 completes in any cycle where mem_read=1.
    logic                  st_valid;
    logic [DM_ADDRESS-1:0] st_addr;
    logic [DATA_W-1:0]     st_data;
    logic [2:0]            st_funct3;
    logic                  ld_valid;
    logic [DM_ADDRESS-1:0] ld_addr;
    logic                  drain_en;

    logic                  stall;
    logic                  mem_read;
    logic                  mem_write;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wd;
    logic [2:0]            mem_funct3;
    logic [CW-1:0]         count;
    logic                  empty;

    modport master (
        output st_valid, st_addr, st_data, st_funct3, ld_valid, ld_addr, drain_en,
        input  stall, mem_read, mem_write, mem_addr, mem_wd, mem_funct3, count, empty
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_funct3, ld_valid, ld_addr, drain_en,
        output stall, mem_read, mem_write, mem_addr, mem_wd, mem_funct3, count, empty
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-store FIFO between EX/MEM and the data memory write port; loads keep
// priority on the port and stall only when they hit a pending store's word.
module store_buffer #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4
) (
    input logic           clk,
    input logic           reset,
    store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DM_ADDRESS-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0]     data_q [DEPTH];
    logic [2:0]            f3_q   [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;

    logic ld_hit;
    logic rd;
    logic drain;
    logic push;
    logic is_empty;

    assign is_empty = (cnt == '0);

    // Walk the occupied slots oldest-first from head; the PW-bit sum wraps.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.ld_valid && (CW'(i) < cnt) &&
                (addr_q[head + PW'(i)][DM_ADDRESS-1:2] == bus.ld_addr[DM_ADDRESS-1:2]))
                ld_hit = 1'b1;
        end
    end

    assign rd    = bus.ld_valid & ~ld_hit;
    assign drain = ~is_empty & bus.drain_en & ~rd;
    assign push  = bus.st_valid & ((cnt < CW'(DEPTH)) | drain);

    always_comb begin
        bus.mem_addr   = '0;
        bus.mem_wd     = '0;
        bus.mem_funct3 = 3'b000;
        if (rd) begin
            bus.mem_addr = bus.ld_addr;
        end else if (drain) begin
            bus.mem_addr   = addr_q[head];
            bus.mem_wd     = data_q[head];
            bus.mem_funct3 = f3_q[head];
        end
    end

    assign bus.mem_read  = rd;
    assign bus.mem_write = drain;
    assign bus.stall     = ld_hit | (bus.st_valid & ~push);
    assign bus.count     = cnt;
    assign bus.empty     = is_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (drain) head <= head + PW'(1);
            if (push)  tail <= tail + PW'(1);
            case ({push, drain})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry payload is never read unless covered by cnt, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= bus.st_addr;
            data_q[tail] <= bus.st_data;
            f3_q[tail]   <= bus.st_funct3;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios then random traffic, all checked
// against a queue-based model of the posted-store buffer.
module tb_store_buffer;
    localparam int DM = 9;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int EW = DM + DW + 3;

    logic clk;
    logic reset;

    store_buffer_if #(.DM_ADDRESS(DM), .DATA_W(DW), .DEPTH(DEPTH)) sb ();

    store_buffer #(.DM_ADDRESS(DM), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sb.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pending stores, oldest first: {addr, data, funct3}
    logic [EW-1:0] exp_q[$];

    int total_cnt = 0;
    int pass_cnt  = 0;

    always @(posedge clk) begin
        assert (!(sb.st_valid && sb.ld_valid))
        else $error("FAIL st_ld_exclusive obs=1 exp=0");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    endtask

    // driver tasks
    task automatic drive(input logic sv, input logic [DM-1:0] sa, input logic [DW-1:0] sd,
                         input logic [2:0] sf, input logic lv, input logic [DM-1:0] la,
                         input logic den);
        sb.st_valid  = sv;
        sb.st_addr   = sa;
        sb.st_data   = sd;
        sb.st_funct3 = sf;
        sb.ld_valid  = lv;
        sb.ld_addr   = la;
        sb.drain_en  = den;
    endtask

    task automatic idle(input logic den);
        drive(1'b0, '0, '0, 3'b000, 1'b0, '0, den);
    endtask

    task automatic store(input logic [DM-1:0] a, input logic [DW-1:0] d, input logic [2:0] f,
                         input logic den);
        drive(1'b1, a, d, f, 1'b0, '0, den);
    endtask

    task automatic load(input logic [DM-1:0] a, input logic den);
        drive(1'b0, '0, '0, 3'b000, 1'b1, a, den);
    endtask

    // Checks all outputs at the falling edge against the model, then applies
    // the model's pop/push at the rising edge.
    task automatic tick();
        logic          hit, rd, dr, pu;
        logic [EW-1:0] h;
        logic [DM-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic [2:0]    e_f3;
        @(negedge clk);
        hit = 1'b0;
        if (sb.ld_valid)
            foreach (exp_q[k])
                if (exp_q[k][EW-1 -: DM-2] == sb.ld_addr[DM-1:2]) hit = 1'b1;
        rd = sb.ld_valid && !hit;
        dr = (exp_q.size() > 0) && sb.drain_en && !rd;
        pu = sb.st_valid && ((exp_q.size() < DEPTH) || dr);
        h  = (exp_q.size() > 0) ? exp_q[0] : '0;
        e_addr = rd ? sb.ld_addr : (dr ? h[EW-1 -: DM] : '0);
        e_wd   = dr ? h[DW+2:3] : '0;
        e_f3   = dr ? h[2:0] : 3'b000;
        check("count",      64'(sb.count),      64'(exp_q.size()));
        check("empty",      64'(sb.empty),      64'(exp_q.size() == 0));
        check("stall",      64'(sb.stall),      64'(hit || (sb.st_valid && !pu)));
        check("mem_read",   64'(sb.mem_read),   64'(rd));
        check("mem_write",  64'(sb.mem_write),  64'(dr));
        check("mem_addr",   64'(sb.mem_addr),   64'(e_addr));
        check("mem_wd",     64'(sb.mem_wd),     64'(e_wd));
        check("mem_funct3", 64'(sb.mem_funct3), 64'(e_f3));
        @(posedge clk);
        if (dr) void'(exp_q.pop_front());
        if (pu) exp_q.push_back({sb.st_addr, sb.st_data, sb.st_funct3});
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle(1'b1);
        #1;
        check("rst_count",     64'(sb.count),     64'd0);
        check("rst_empty",     64'(sb.empty),     64'd1);
        check("rst_stall",     64'(sb.stall),     64'd0);
        check("rst_mem_write", 64'(sb.mem_write), 64'd0);
        check("rst_mem_addr",  64'(sb.mem_addr),  64'd0);
        check("rst_mem_wd",    64'(sb.mem_wd),    64'd0);
        load(9'h0A4, 1'b1);
        #1;
        check("rst_mem_read",   64'(sb.mem_read), 64'd1);
        check("rst_ld_addr",    64'(sb.mem_addr), 64'h0A4);
        idle(1'b1);
        #10;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // single store then drain
        store(9'h010, 32'hDEADBEEF, 3'b010, 1'b1);
        tick();
        check("t1_count_after_push", 64'(sb.count), 64'd1);
        idle(1'b1);
        #1;
        check("t1_drain_addr", 64'(sb.mem_addr), 64'h010);
        check("t1_drain_wd",   64'(sb.mem_wd),   64'hDEADBEEF);
        tick();
        check("t1_count_after_pop", 64'(sb.count), 64'd0);

        // fill with drain withheld, then push-while-draining when full
        for (int i = 0; i < 4; i++) begin
            store(9'(4 * i), 32'hA000_0000 + 32'(i), 3'b010, 1'b0);
            tick();
        end
        store(9'h050, 32'h5555_5555, 3'b010, 1'b0);
        #1;
        check("t2_full_stall", 64'(sb.stall), 64'd1);
        tick();
        store(9'h050, 32'h5555_5555, 3'b010, 1'b1);
        #1;
        check("t2_push_on_drain_stall", 64'(sb.stall), 64'd0);
        tick();
        check("t2_count_stays_4", 64'(sb.count), 64'd4);
        idle(1'b1);
        repeat (5) tick();

        // load hazard on pending word resolves after the head drains
        store(9'h020, 32'h1234_5678, 3'b010, 1'b1);
        tick();
        load(9'h022, 1'b1);
        #1;
        check("t3_hit_stall", 64'(sb.stall),    64'd1);
        check("t3_hit_noread", 64'(sb.mem_read), 64'd0);
        tick();
        check("t3_issue", 64'(sb.mem_read), 64'd1);
        tick();

        // non-matching loads keep the port; store waits
        store(9'h040, 32'hCAFE_F00D, 3'b001, 1'b1);
        tick();
        load(9'h044, 1'b1);
        repeat (3) tick();
        idle(1'b1);
        tick();

        // wrap-around with interleaved drains and a probing load
        for (int i = 0; i < 10; i++) begin
            store(9'h100 + 9'(4 * i), 32'h100 + 32'(i), 3'b010, 1'((i % 3) != 0));
            tick();
            load(9'h11C, 1'b0);
            tick();
            idle(1'b1);
            tick();
        end
        idle(1'b1);
        repeat (6) tick();

        // asynchronous reset mid-cycle with three pending stores
        for (int i = 0; i < 3; i++) begin
            store(9'h180 + 9'(4 * i), 32'hBAD0_0000 + 32'(i), 3'b010, 1'b0);
            tick();
        end
        idle(1'b1);
        #1;
        reset = 1'b1;
        #1;
        check("t6_count",     64'(sb.count),     64'd0);
        check("t6_empty",     64'(sb.empty),     64'd1);
        check("t6_mem_write", 64'(sb.mem_write), 64'd0);
        exp_q.delete();
        #1;
        reset = 1'b0;
        repeat (3) tick();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            int op;
            op = $urandom_range(0, 2);
            if (op == 1)
                store(9'($urandom_range(0, 31)), $urandom, 3'($urandom_range(0, 2)),
                      1'($urandom_range(0, 3) != 0));
            else if (op == 2)
                load(9'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0));
            else
                idle(1'($urandom_range(0, 3) != 0));
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-store write buffer in the MEM stage of the RISC-V pipeline, directly upstream of the data memory. Stores from the EX/MEM register are queued in a small FIFO and drained to the data memory write port whenever that port is not needed by a load, so stores do not hold the pipeline. Loads keep priority on the memory port. A load that hits a pending store's word stalls until that entry has drained.

## Interface
- `DM_ADDRESS`, 9: data memory byte-address width.
- `DATA_W`, 32: store data width.
- `DEPTH`, 4: FIFO entries; must be a power of two, ≥2.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `st_valid` in 1: store instruction present in MEM this cycle.
- `st_addr` in DM_ADDRESS: store byte address (ALU result LSBs).
- `st_data` in DATA_W: store data (rs2).
- `st_funct3` in 3: store funct3.
- `ld_valid` in 1: load instruction present in MEM this cycle.
- `ld_addr` in DM_ADDRESS: load byte address.
- `drain_en` in 1: permits draining this cycle (0 = memory port withheld externally).
- `stall` out 1: hold the IF through MEM stages this cycle.
- `mem_read` out 1: MemRead to data memory.
- `mem_write` out 1: MemWrite to data memory.
- `mem_addr` out DM_ADDRESS: address to data memory.
- `mem_wd` out DATA_W: write data to data memory.
- `mem_funct3` out 3: Funct3 to data memory (load funct3 is not carried here; `mem_funct3` = head funct3 on drain, else 3'b000; the MEM stage muxes the load funct3).
- `count` out $clog2(DEPTH)+1: occupied entries.
- `empty` out 1: `count == 0`.

## Operation
- Storage: DEPTH entries of {addr, data, funct3}, plus head pointer, tail pointer and count. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Load hazard: `ld_hit` = `ld_valid` and some valid entry has `addr[DM_ADDRESS-1:2] == ld_addr[DM_ADDRESS-1:2]`. Compare against all valid entries, wrap-aware.
- Load issue: `mem_read = ld_valid & ~ld_hit`. When `mem_read` is 1, `mem_addr = ld_addr`.
- Drain: `drain = ~empty & drain_en & ~mem_read`. When `drain` is 1:
  - `mem_write` = 1.
  - `mem_addr` = head addr, `mem_wd` = head data, `mem_funct3` = head funct3.
  - Head pops at the rising edge.
- Idle outputs: when neither load issue nor drain occurs, `mem_addr` = 0 and `mem_wd` = 0.
- Push: `push = st_valid & (count < DEPTH | drain)`. The entry is written at tail at the rising edge. Push and pop in the same cycle leave `count` unchanged. This is allowed when full if a drain occurs.
- Stall: `stall = ld_hit | (st_valid & ~push)`.
- `st_valid` and `ld_valid` must never both be 1. The bench asserts this. If violated, the store is processed and the load is treated as issued, with no guarantee on correctness.
- Ordering: strict FIFO. Only the head drains.
- Reset: asynchronous. It clears the pointers and count immediately and discards pending stores. Entry contents need not be cleared.

## Timing
- Reset values: `count` = 0, `empty` = 1, `stall` = 0 (if `ld_valid` = 0 and `st_valid` = 0), `mem_write` = 0, `mem_read` = `ld_valid`, `mem_addr` = `ld_addr` or 0, `mem_wd` = 0.
- All outputs are combinational from state and current inputs. No output registers.
- Data memory writes on the falling edge of `clk`. The drained entry is therefore committed mid-cycle, before the pop at the following rising edge.
- A store accepted at edge N is drainable in cycle N+1 at the earliest.
- A stalled load re-evaluates every cycle. It issues in the first cycle in which no matching entry remains.
- A hazard with the head entry resolves in 1 cycle when `drain_en` = 1. In general, k entries up to the youngest match need k cycles.
- With `drain_en` held at 0, a hazarded load stalls indefinitely. A full buffer with `st_valid` = 1 also stalls indefinitely. Both are the required behaviour.

## Test plan
- Reset, then a single store (`st_addr` = 0x010, `st_data` = 0xDEADBEEF, funct3 = 010) with no loads. Required: `count` = 1 after edge 1. Next cycle `mem_write` = 1, `mem_addr` = 0x010, `mem_wd` = 0xDEADBEEF. `count` = 0 after edge 2.
- Hold `drain_en` = 0 and push 4 stores to 0x000, 0x004, 0x008, 0x00C. Then present a 5th store. Required: `count` = 4 and `stall` = 1 on the 5th. Raise `drain_en`: the 5th is accepted the same cycle as the 0x000 drain, `count` stays 4, and drain order is 0x000, 0x004, 0x008, 0x00C, then the 5th.
- Pending store to 0x020. Load `ld_addr` = 0x022 (same word). Required: `stall` = 1 and `mem_read` = 0 for 1 cycle while 0x020 drains, then `mem_read` = 1 and `stall` = 0.
- Pending store to 0x040. Load 0x044 every cycle for 3 cycles. Required: `mem_read` = 1 with no stall, `mem_write` = 0 for those 3 cycles. The store drains in the first cycle without a load.
- Wrap-around: 10 stores (0x100 + 4i), interleaved with drains so the pointers pass DEPTH twice. Required: drain order is strictly ascending. A load at 0x11C hits only while entry 0x11C is pending.
- Assert `reset` mid-cycle with `count` = 3. Required: `count` = 0, `empty` = 1 and `mem_write` = 0 immediately, without waiting for a clock edge. No old entry drains after reset.
